// File: rtl/pixel_fp_normalizer.sv
// Normalizes the three channels of an RGB pixel into single-precision style
// significand/exponent/zero form, then handshakes with the mantissa multiplier.
// Optional macro PIX_ZERO_BYPASS_EN: an all-zero pixel skips the multiplier wait.
module pixel_fp_normalizer #(
    parameter int PIXEL_WIDTH    = 8,
    parameter int MANTISSA_WIDTH = 23,
    parameter int EXPONENT_WIDTH = 8,
    parameter int BIAS           = 127
) (
    input  logic                      clk_i_pix_norm,
    input  logic                      rstn_i_pix_norm,
    input  logic                      pix_valid_i,
    output logic                      pix_ready_o,
    input  logic [PIXEL_WIDTH-1:0]    pixel_red_i,
    input  logic [PIXEL_WIDTH-1:0]    pixel_green_i,
    input  logic [PIXEL_WIDTH-1:0]    pixel_blue_i,
    output logic [MANTISSA_WIDTH:0]   mantissa_red_o,
    output logic [MANTISSA_WIDTH:0]   mantissa_green_o,
    output logic [MANTISSA_WIDTH:0]   mantissa_blue_o,
    output logic [EXPONENT_WIDTH-1:0] exponent_red_o,
    output logic [EXPONENT_WIDTH-1:0] exponent_green_o,
    output logic [EXPONENT_WIDTH-1:0] exponent_blue_o,
    output logic                      zero_red_o,
    output logic                      zero_green_o,
    output logic                      zero_blue_o,
    output logic                      mult_en_o,
    input  logic                      mult_done_i,
    output logic                      norm_done_o,
    output logic [2:0]                state_dbg_o
);

    localparam int CNT_W    = (PIXEL_WIDTH > 1) ? $clog2(PIXEL_WIDTH) : 1;
    localparam int PAD_W    = MANTISSA_WIDTH + 1 - PIXEL_WIDTH;
    localparam int EXP_TOP  = BIAS + PIXEL_WIDTH - 1;

    // Handshakes: a pixel transfers on a rising edge where pix_valid_i and
    // pix_ready_o are both high; mult_en_o is held until mult_done_i is seen high.
    typedef enum logic [2:0] {
        S_IDLE, S_NORM_R, S_NORM_G, S_NORM_B, S_WAIT, S_DONE
    } state_t;

    state_t                   state, state_nxt;
    logic [PIXEL_WIDTH-1:0]   work_red, work_green, work_blue;
    logic [CNT_W-1:0]         count;
    logic [PIXEL_WIDTH-1:0]   cur_val;
    logic                     ch_zero, ch_msb, ch_settle, bypass;
    logic [MANTISSA_WIDTH:0]  new_mant;
    logic [EXPONENT_WIDTH-1:0] new_exp;

    always_comb begin
        cur_val = '0;
        case (state)
            S_NORM_R: cur_val = work_red;
            S_NORM_G: cur_val = work_green;
            S_NORM_B: cur_val = work_blue;
            default:  cur_val = '0;
        endcase
    end

    assign ch_zero   = (cur_val == '0);
    assign ch_msb    = cur_val[PIXEL_WIDTH-1];
    assign ch_settle = ch_zero | ch_msb;
    assign new_mant  = {cur_val, {PAD_W{1'b0}}};
    assign new_exp   = EXPONENT_WIDTH'(EXP_TOP) - EXPONENT_WIDTH'(count);

`ifdef PIX_ZERO_BYPASS_EN
    // Red and green flags already belong to this pixel when blue settles.
    assign bypass = zero_red_o & zero_green_o & ch_zero;
`else
    assign bypass = 1'b0;
`endif

    always_ff @(posedge clk_i_pix_norm or negedge rstn_i_pix_norm) begin
        if (!rstn_i_pix_norm) state <= S_IDLE;
        else                  state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (pix_valid_i) state_nxt = S_NORM_R;
            S_NORM_R: if (ch_settle)   state_nxt = S_NORM_G;
            S_NORM_G: if (ch_settle)   state_nxt = S_NORM_B;
            S_NORM_B: if (ch_settle)   state_nxt = bypass ? S_DONE : S_WAIT;
            S_WAIT:   if (mult_done_i) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    assign pix_ready_o = (state == S_IDLE);
    assign mult_en_o   = (state == S_WAIT);
    assign norm_done_o = (state == S_DONE);
    assign state_dbg_o = state;

    always_ff @(posedge clk_i_pix_norm or negedge rstn_i_pix_norm) begin
        if (!rstn_i_pix_norm) begin
            work_red         <= '0;
            work_green       <= '0;
            work_blue        <= '0;
            count            <= '0;
            mantissa_red_o   <= '0;
            mantissa_green_o <= '0;
            mantissa_blue_o  <= '0;
            exponent_red_o   <= '0;
            exponent_green_o <= '0;
            exponent_blue_o  <= '0;
            zero_red_o       <= 1'b0;
            zero_green_o     <= 1'b0;
            zero_blue_o      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pix_valid_i) begin
                        work_red   <= pixel_red_i;
                        work_green <= pixel_green_i;
                        work_blue  <= pixel_blue_i;
                        count      <= '0;
                    end
                end
                S_NORM_R: begin
                    if (ch_settle) begin
                        mantissa_red_o <= ch_zero ? '0 : new_mant;
                        exponent_red_o <= ch_zero ? '0 : new_exp;
                        zero_red_o     <= ch_zero;
                        count          <= '0;
                    end else begin
                        work_red <= work_red << 1;
                        count    <= count + CNT_W'(1);
                    end
                end
                S_NORM_G: begin
                    if (ch_settle) begin
                        mantissa_green_o <= ch_zero ? '0 : new_mant;
                        exponent_green_o <= ch_zero ? '0 : new_exp;
                        zero_green_o     <= ch_zero;
                        count            <= '0;
                    end else begin
                        work_green <= work_green << 1;
                        count      <= count + CNT_W'(1);
                    end
                end
                S_NORM_B: begin
                    if (ch_settle) begin
                        mantissa_blue_o <= ch_zero ? '0 : new_mant;
                        exponent_blue_o <= ch_zero ? '0 : new_exp;
                        zero_blue_o     <= ch_zero;
                        count           <= '0;
                    end else begin
                        work_blue <= work_blue << 1;
                        count     <= count + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_fp_normalizer.sv
// Self-checking bench for pixel_fp_normalizer: directed test-plan pixels,
// reset scenarios and randomized pixels against a leading-one reference model.
module tb_pixel_fp_normalizer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_valid_i = 1'b0;
    logic        pix_ready_o;
    logic [7:0]  pixel_red_i = '0, pixel_green_i = '0, pixel_blue_i = '0;
    logic [23:0] mantissa_red_o, mantissa_green_o, mantissa_blue_o;
    logic [7:0]  exponent_red_o, exponent_green_o, exponent_blue_o;
    logic        zero_red_o, zero_green_o, zero_blue_o;
    logic        mult_en_o;
    logic        mult_done_i = 1'b0;
    logic        norm_done_o;
    logic [2:0]  state_dbg_o;

    int checks = 0;
    int failures = 0;

    pixel_fp_normalizer dut (
        .clk_i_pix_norm   (clk),
        .rstn_i_pix_norm  (rst_n),
        .pix_valid_i      (pix_valid_i),
        .pix_ready_o      (pix_ready_o),
        .pixel_red_i      (pixel_red_i),
        .pixel_green_i    (pixel_green_i),
        .pixel_blue_i     (pixel_blue_i),
        .mantissa_red_o   (mantissa_red_o),
        .mantissa_green_o (mantissa_green_o),
        .mantissa_blue_o  (mantissa_blue_o),
        .exponent_red_o   (exponent_red_o),
        .exponent_green_o (exponent_green_o),
        .exponent_blue_o  (exponent_blue_o),
        .zero_red_o       (zero_red_o),
        .zero_green_o     (zero_green_o),
        .zero_blue_o      (zero_blue_o),
        .mult_en_o        (mult_en_o),
        .mult_done_i      (mult_done_i),
        .norm_done_o      (norm_done_o),
        .state_dbg_o      (state_dbg_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Float form of an unsigned integer: value = 1.m * 2^pos, pos = index of top set bit.
    function automatic void model(input logic [7:0] v, output logic [23:0] m,
                                  output logic [7:0] e, output logic z, output int lat);
        int pos;
        pos = 0;
        z = (v == 8'd0);
        m = '0;
        e = '0;
        lat = 1;
        if (!z) begin
            for (int i = 0; i < 8; i++) if (v[i]) pos = i;
            m = 24'(v) << (23 - pos);
            e = 8'(127 + pos);
            lat = 1 + (7 - pos);
        end
    endfunction

    // ---------------- driver ----------------
    // Runs one pixel from capture until the block is ready again; hold = number
    // of mult_en cycles with mult_done low (0 means mult_done tied high).
    task automatic drive_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                               input int hold, input bit noise,
                               output int en_cyc, output int done_cyc, output int done_pulses,
                               output int en_high, output int ready_busy, output int ready_cyc,
                               output bit timeout);
        int n;
        int wait_seen;
        bit finished;
        en_cyc = -1; done_cyc = -1; done_pulses = 0; en_high = 0;
        ready_busy = 0; ready_cyc = -1; timeout = 1'b0; wait_seen = 0;
        n = 0;
        while (!pix_ready_o && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!pix_ready_o) begin
            timeout = 1'b1;
            return;
        end
        pixel_red_i = r; pixel_green_i = g; pixel_blue_i = b;
        pix_valid_i = 1'b1;
        mult_done_i = (hold == 0);
        @(posedge clk); #1;
        pix_valid_i = 1'b0;
        pixel_red_i = 8'($urandom); pixel_green_i = 8'($urandom); pixel_blue_i = 8'($urandom);
        n = 1;
        finished = 1'b0;
        while (!finished && n <= 200) begin
            if (mult_en_o) begin
                en_high++; wait_seen++;
                if (en_cyc < 0) en_cyc = n;
            end
            if (norm_done_o) begin
                done_pulses++; done_cyc = n;
            end
            if (pix_ready_o) begin
                if (done_pulses > 0) begin
                    ready_cyc = n; finished = 1'b1;
                end else ready_busy++;
            end
            if (!finished) begin
                mult_done_i = (hold == 0) || (wait_seen > hold);
                if (noise) begin
                    pix_valid_i = 1'($urandom_range(0, 1));
                    pixel_red_i = 8'($urandom); pixel_green_i = 8'($urandom); pixel_blue_i = 8'($urandom);
                end
                @(posedge clk); #1; n++;
            end
        end
        pix_valid_i = 1'b0;
        mult_done_i = 1'b0;
        if (!finished) timeout = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({mantissa_red_o, mantissa_green_o, mantissa_blue_o} !== '0) begin
            failures++; $display("FAIL reset_mantissa got %h/%h/%h want 0", mantissa_red_o, mantissa_green_o, mantissa_blue_o);
        end
        checks++;
        if ({exponent_red_o, exponent_green_o, exponent_blue_o} !== '0) begin
            failures++; $display("FAIL reset_exponent got %0d/%0d/%0d want 0", exponent_red_o, exponent_green_o, exponent_blue_o);
        end
        checks++;
        if ({zero_red_o, zero_green_o, zero_blue_o} !== 3'b000) begin
            failures++; $display("FAIL reset_zero got %b%b%b want 000", zero_red_o, zero_green_o, zero_blue_o);
        end
        checks++;
        if ({pix_ready_o, mult_en_o, norm_done_o} !== 3'b100) begin
            failures++; $display("FAIL reset_ctrl ready/en/done got %b%b%b want 100", pix_ready_o, mult_en_o, norm_done_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Full check of one pixel against the model.
    task automatic test_pixel(input string name, input logic [7:0] r, input logic [7:0] g,
                              input logic [7:0] b, input int hold, input bit noise);
        logic [23:0] em[3];
        logic [7:0]  ee[3];
        logic        ez[3];
        int          lat[3];
        int          en_cyc, done_cyc, pulses, en_high, ready_busy, ready_cyc;
        int          exp_en, exp_done;
        bit          timeout, byp;
        model(r, em[0], ee[0], ez[0], lat[0]);
        model(g, em[1], ee[1], ez[1], lat[1]);
        model(b, em[2], ee[2], ez[2], lat[2]);
        drive_pixel(r, g, b, hold, noise, en_cyc, done_cyc, pulses, en_high, ready_busy, ready_cyc, timeout);
        checks++;
        if (timeout) begin
            failures++; $display("FAIL %s_timeout pixel did not complete within bound", name);
            return;
        end
`ifdef PIX_ZERO_BYPASS_EN
        byp = ez[0] && ez[1] && ez[2];
`else
        byp = 1'b0;
`endif
        exp_en   = byp ? -1 : 1 + lat[0] + lat[1] + lat[2];
        exp_done = byp ? 1 + lat[0] + lat[1] + lat[2] : exp_en + hold + 1;
        checks++;
        if ({mantissa_red_o, mantissa_green_o, mantissa_blue_o} !== {em[0], em[1], em[2]}) begin
            failures++; $display("FAIL %s_mantissa got %h/%h/%h want %h/%h/%h", name,
                mantissa_red_o, mantissa_green_o, mantissa_blue_o, em[0], em[1], em[2]);
        end
        checks++;
        if ({exponent_red_o, exponent_green_o, exponent_blue_o} !== {ee[0], ee[1], ee[2]}) begin
            failures++; $display("FAIL %s_exponent got %0d/%0d/%0d want %0d/%0d/%0d", name,
                exponent_red_o, exponent_green_o, exponent_blue_o, ee[0], ee[1], ee[2]);
        end
        checks++;
        if ({zero_red_o, zero_green_o, zero_blue_o} !== {ez[0], ez[1], ez[2]}) begin
            failures++; $display("FAIL %s_zero got %b%b%b want %b%b%b", name,
                zero_red_o, zero_green_o, zero_blue_o, ez[0], ez[1], ez[2]);
        end
        checks++;
        if (en_cyc !== exp_en) begin
            failures++; $display("FAIL %s_en_latency got %0d want %0d", name, en_cyc, exp_en);
        end
        checks++;
        if (en_high !== (byp ? 0 : hold + 1)) begin
            failures++; $display("FAIL %s_en_width got %0d want %0d", name, en_high, byp ? 0 : hold + 1);
        end
        checks++;
        if (done_cyc !== exp_done || pulses !== 1) begin
            failures++; $display("FAIL %s_done got cycle %0d pulses %0d want cycle %0d pulses 1", name, done_cyc, pulses, exp_done);
        end
        checks++;
        if (ready_busy !== 0 || ready_cyc !== exp_done + 1) begin
            failures++; $display("FAIL %s_ready busy_ready %0d idle_at %0d want 0 and %0d", name, ready_busy, ready_cyc, exp_done + 1);
        end
    endtask

    task automatic test_directed();
        test_pixel("plan_a", 8'h80, 8'hFF, 8'h01, 0, 1'b0);
        test_pixel("plan_b", 8'h03, 8'h40, 8'h10, 0, 1'b0);
    endtask

    task automatic test_zero_green();
        test_pixel("zero_green", 8'hA5, 8'h00, 8'h3C, 1, 1'b0);
    endtask

    task automatic test_wait_hold();
        test_pixel("wait_hold", 8'h21, 8'h07, 8'hC0, 20, 1'b1);
    endtask

    task automatic test_all_zero();
        test_pixel("all_zero", 8'h00, 8'h00, 8'h00, 2, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 30; i++) begin
            logic [7:0] r, g, b;
            r = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            g = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            b = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            test_pixel("random", r, g, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid();
        int n;
        // Red 0x80 settles in one cycle, so the second cycle after capture is NORM_G.
        pixel_red_i = 8'h80; pixel_green_i = 8'h01; pixel_blue_i = 8'h55;
        pix_valid_i = 1'b1;
        @(posedge clk); #1;
        pix_valid_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mantissa_red_o, exponent_red_o, zero_red_o, zero_green_o} !== '0) begin
            failures++; $display("FAIL rst_mid_outputs got mant_r %h exp_r %0d zr %b zg %b want 0", mantissa_red_o, exponent_red_o, zero_red_o, zero_green_o);
        end
        checks++;
        if ({pix_ready_o, mult_en_o, norm_done_o} !== 3'b100) begin
            failures++; $display("FAIL rst_mid_ctrl ready/en/done got %b%b%b want 100", pix_ready_o, mult_en_o, norm_done_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_pixel("after_rst_norm", 8'h5A, 8'h02, 8'hFE, 0, 1'b0);
        // Reset while the multiplier enable is held high.
        pixel_red_i = 8'h11; pixel_green_i = 8'h22; pixel_blue_i = 8'h44;
        pix_valid_i = 1'b1;
        mult_done_i = 1'b0;
        @(posedge clk); #1;
        pix_valid_i = 1'b0;
        n = 0;
        while (!mult_en_o && n < 60) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (mult_en_o !== 1'b1) begin
            failures++; $display("FAIL rst_wait_reach mult_en got %b want 1", mult_en_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mult_en_o, pix_ready_o, mantissa_blue_o} !== {1'b0, 1'b1, 24'h0}) begin
            failures++; $display("FAIL rst_wait_async en %b ready %b mant_b %h want 0 1 0", mult_en_o, pix_ready_o, mantissa_blue_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_pixel("after_rst_wait", 8'h01, 8'h80, 8'h00, 3, 1'b0);
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_directed();
        test_zero_green();
        test_wait_hold();
        test_all_zero();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
